// File: rtl/stream_demux_1_to_n.sv
// 1-to-N stream demultiplexer with packet lock and a one-beat registered slot per lane.
// Beats with a route outside the lane range are accepted, discarded and counted.
module stream_demux_1_to_n #(
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned SEL_W  = 1,
  parameter int unsigned DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        sel,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_last,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_last,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic                    locked,
  output logic [7:0]              drop_count
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [SEL_W-1:0]          lock_sel_q, lock_sel_d;
  logic [N_OUT-1:0]          valid_q, valid_d;
  logic [N_OUT-1:0]          last_q, last_d;
  logic [N_OUT*DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]          drop_q, drop_d;

  logic [SEL_W-1:0]          route_c;
  logic [N_OUT-1:0]          hit_c;
  logic                      route_ok_c;
  logic                      accept_c;

  // Route decode: one-hot lane hit; no hit means the route is out of range.
  always_comb begin
    route_c = (state_q == ST_LOCKED) ? lock_sel_q : sel;
    hit_c   = '0;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (32'(route_c) == k) hit_c[k] = 1'b1;
    end
    route_ok_c = |hit_c;
    in_ready   = ~route_ok_c | (|(hit_c & (~valid_q | out_ready)));
    accept_c   = in_valid & in_ready;
  end

  // Packet lock FSM: route latched on the first beat, released on in_last.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    if (accept_c) begin
      case (state_q)
        ST_IDLE: begin
          if (!in_last) begin
            state_d    = ST_LOCKED;
            lock_sel_d = sel;
          end
        end
        ST_LOCKED: begin
          if (in_last) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Lane slots: a fill wins over a drain so a full lane streams at one beat per clock.
  always_comb begin
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    for (int unsigned k = 0; k < N_OUT; k++) begin
      if (accept_c && hit_c[k]) begin
        valid_d[k]                   = 1'b1;
        last_d[k]                    = in_last;
        data_d[k*DATA_W +: DATA_W]   = in_data;
      end else if (valid_q[k] && out_ready[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  // Saturating drop counter for out-of-range beats.
  always_comb begin
    drop_d = drop_q;
    if (accept_c && !route_ok_c && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= '0;
      valid_q    <= '0;
      last_q     <= '0;
      data_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      data_q     <= data_d;
      drop_q     <= drop_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_last   = last_q;
  assign out_data   = data_q;
  assign locked     = (state_q == ST_LOCKED);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_stream_demux_1_to_n.sv
// Bench for stream_demux_1_to_n (3 lanes, 2-bit sel): vector table plus
// per-lane scoreboard queues that predict in_ready, lane contents and drop count.
module tb_stream_demux_1_to_n;

  localparam int unsigned N_OUT  = 3;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NVEC   = 12;

  logic                    clk;
  logic                    reset;
  logic [SEL_W-1:0]        sel;
  logic [DATA_W-1:0]       in_data;
  logic                    in_last;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_last;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic                    locked;
  logic [7:0]              drop_count;

  stream_demux_1_to_n #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [7:0] data;
    logic       last;
    logic [2:0] rdy;
    logic       ir;   // in_ready expected before the edge
    logic [2:0] ov;   // out_valid expected after the edge
    logic       lk;   // locked expected after the edge
  } vec_t;

  vec_t vecs [NVEC];

  // Scoreboard: beats ({last, data}) expected on each lane, oldest first.
  logic [8:0] sb_q [N_OUT][$];
  logic       m_locked;
  logic [1:0] m_sel;
  int         m_drop;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_state();
    for (int k = 0; k < int'(N_OUT); k++) begin
      chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(sb_q[k].size() != 0));
      if (sb_q[k].size() != 0) begin
        chk($sformatf("out_data[%0d]", k), 32'(out_data[k*8 +: 8]), 32'(sb_q[k][0][7:0]));
        chk($sformatf("out_last[%0d]", k), 32'(out_last[k]), 32'(sb_q[k][0][8]));
      end
    end
    chk("locked", 32'(locked), 32'(m_locked));
    chk("drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  // One clock: drive at negedge, check before the rising edge, update model on it.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic l, input logic [2:0] r, output logic ir_seen);
    logic [1:0] rt;
    logic       ok;
    logic       exp_ir;
    in_valid  = v;
    sel       = s;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
    rt = m_locked ? m_sel : s;
    ok = (rt < 2'd3);
    if (!ok) exp_ir = 1'b1;
    else     exp_ir = (sb_q[rt].size() == 0) || r[rt];
    chk_state();
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    ir_seen = in_ready;
    @(posedge clk);
    for (int k = 0; k < int'(N_OUT); k++) begin
      if (sb_q[k].size() != 0 && r[k]) void'(sb_q[k].pop_front());
    end
    if (v && exp_ir) begin
      if (ok) sb_q[rt].push_back({l, d});
      else if (m_drop < 255) m_drop++;
      if (!m_locked && !l) begin
        m_locked = 1'b1;
        m_sel    = s;
      end else if (m_locked && l) begin
        m_locked = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    sel       = '0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < int'(N_OUT); k++) sb_q[k].delete();
    m_locked = 1'b0;
    m_sel    = '0;
    m_drop   = 0;
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_data", 32'(out_data), 32'd0);
    chk("rst out_last", 32'(out_last), 32'd0);
    chk("rst locked", 32'(locked), 32'd0);
    chk("rst drop_count", 32'(drop_count), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ir;
    //           v     sel   data   last  rdy     ir    ov      lk
    vecs[0]  = '{1'b1, 2'd1, 8'hA5, 1'b1, 3'b000, 1'b1, 3'b010, 1'b0}; // single beat lane1
    vecs[1]  = '{1'b0, 2'd1, 8'h00, 1'b0, 3'b010, 1'b1, 3'b000, 1'b0}; // drain lane1
    vecs[2]  = '{1'b1, 2'd0, 8'h11, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1}; // packet beat 1
    vecs[3]  = '{1'b1, 2'd1, 8'h22, 1'b0, 3'b111, 1'b1, 3'b001, 1'b1}; // sel ignored
    vecs[4]  = '{1'b1, 2'd1, 8'h33, 1'b1, 3'b111, 1'b1, 3'b001, 1'b0}; // last beat
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b0, 3'b111, 1'b1, 3'b000, 1'b0};
    vecs[6]  = '{1'b1, 2'd0, 8'hC3, 1'b1, 3'b000, 1'b1, 3'b001, 1'b0}; // fill lane0
    vecs[7]  = '{1'b1, 2'd0, 8'h99, 1'b1, 3'b000, 1'b0, 3'b001, 1'b0}; // blocked
    vecs[8]  = '{1'b1, 2'd1, 8'h5A, 1'b1, 3'b000, 1'b1, 3'b011, 1'b0}; // other lane free
    vecs[9]  = '{1'b0, 2'd0, 8'h00, 1'b0, 3'b011, 1'b1, 3'b000, 1'b0};
    vecs[10] = '{1'b1, 2'd3, 8'hEE, 1'b0, 3'b000, 1'b1, 3'b000, 1'b1}; // out-of-range packet
    vecs[11] = '{1'b1, 2'd0, 8'hEF, 1'b1, 3'b000, 1'b1, 3'b000, 1'b0}; // still dropped

    do_reset();

    for (int i = 0; i < int'(NVEC); i++) begin
      cycle(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].last, vecs[i].rdy, ir);
      chk($sformatf("vec%0d in_ready", i), 32'(ir), 32'(vecs[i].ir));
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("vec%0d locked", i), 32'(locked), 32'(vecs[i].lk));
    end
    chk("drop after table", 32'(drop_count), 32'd2);

    // Back-to-back streaming through lane 2 with consumer always ready.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 2'd2, 8'(8'h40 + i), 1'(i == 5), 3'b100, ir);
      chk("stream in_ready", 32'(ir), 32'd1);
    end
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 3'b100, ir);

    // 300 single-beat drops: counter must saturate at 255.
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, 2'd3, 8'(i), 1'b1, 3'b000, ir);
    end
    chk("drop saturated", 32'(drop_count), 32'd255);
    chk("drop no lanes", 32'(out_valid), 32'd0);
    cycle(1'b1, 2'd3, 8'h01, 1'b1, 3'b000, ir);
    chk("drop holds", 32'(drop_count), 32'd255);

    // Reset in the middle of a 4-beat packet with lane 1 full.
    do_reset();
    cycle(1'b1, 2'd1, 8'h77, 1'b1, 3'b000, ir);
    cycle(1'b1, 2'd0, 8'h01, 1'b0, 3'b001, ir);
    cycle(1'b1, 2'd0, 8'h02, 1'b0, 3'b001, ir);
    chk("pre-reset locked", 32'(locked), 32'd1);
    chk("pre-reset out_valid", 32'(out_valid), 32'b011);
    do_reset();
    cycle(1'b1, 2'd2, 8'h03, 1'b0, 3'b000, ir);
    chk("post-reset route", 32'(out_valid), 32'b100);
    chk("post-reset lane2 data", 32'(out_data[16 +: 8]), 32'h03);
    chk("post-reset locked", 32'(locked), 32'd1);
    cycle(1'b1, 2'd0, 8'h04, 1'b1, 3'b100, ir);
    cycle(1'b0, 2'd0, 8'h00, 1'b0, 3'b111, ir);
    chk("final idle", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_to_n.md
Name: stream_demux_1_to_n

Overview:
- Inverse of the team's 2-to-1 select mux: routes one input stream to one of N_OUT output streams.
- Valid/ready handshake on all sides; one registered slot per output.
- Packet lock: the route is latched on the first beat and held until the beat carrying in_last.
- Sits between a single producer and N consumer lanes, e.g. fanning a test stream out to parallel checkers.

Parameters:
- N_OUT, 2, number of output lanes (2..16).
- SEL_W, 1, width of sel; must satisfy 2**SEL_W >= N_OUT.
- DATA_W, 8, payload width per beat.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- sel  input  SEL_W  destination lane, sampled only on the first beat of a packet.
- in_data  input  DATA_W  input payload.
- in_last  input  1  marks the final beat of a packet.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- out_data  output  N_OUT*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
- out_last  output  N_OUT  per-lane last flag.
- out_valid  output  N_OUT  per-lane slot full.
- out_ready  input  N_OUT  per-lane consumer ready.
- locked  output  1  high while mid-packet (state LOCKED).
- drop_count  output  8  count of beats discarded due to an out-of-range route; saturates at 255.

Behaviour:
- Accept = in_valid & in_ready; lane drain k = out_valid[k] & out_ready[k]. All state updates on the rising edge of clk.
- Reset (sync, highest priority):
  - All slots empty: out_valid = 0, out_data = 0, out_last = 0.
  - State IDLE, locked = 0, drop_count = 0.
  - A packet in flight is abandoned and buffered beats are lost.
- FSM IDLE:
  - route = sel (current cycle).
  - Accept with in_last = 0 → LOCKED, lock_sel <= sel.
  - Accept with in_last = 1 → stay IDLE (single-beat packet).
- FSM LOCKED:
  - route = lock_sel; sel is ignored.
  - Accept with in_last = 1 → IDLE.
  - locked = 1 only in LOCKED.
- in_ready (combinational, no dependency on in_valid):
  - Valid route (route < N_OUT): in_ready = ~out_valid[route] | out_ready[route].
  - Out-of-range route: in_ready = 1 (sink).
- Slot k update:
  - Accept to lane k: slot loads in_data/in_last; out_valid[k] <= 1.
  - Else if drain k: out_valid[k] <= 0; out_data/out_last hold their last values.
  - Simultaneous drain and fill of the same lane: slot reloads with the new beat and out_valid stays 1, giving full throughput of one beat per clock.
- Latency: exactly 1 cycle from accept to out_valid on the target lane.
- Stability: out_data/out_last of a full slot are stable while out_ready is low.
- Non-target lanes are unaffected by an accept and drain independently.
- Out-of-range route:
  - The beat is accepted and discarded; drop_count += 1, saturating at 255, never wraps.
  - FSM transitions still apply; an out-of-range packet locks and all of its beats are dropped.
- Inactive inputs: sel changes mid-packet have no effect; in_data/in_last are don't-care when in_valid = 0.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready[route].

Test Plan:
- Reset then idle: out_valid = 0, locked = 0, drop_count = 0, in_ready = 1.
- Single beat: sel = 1, in_data = 0xA5, in_last = 1, accepted at cycle t → out_valid = 2'b10 at t+1 with lane1 data 0xA5 and out_last[1] = 1; locked stays 0. Raise out_ready[1] → out_valid = 0 next cycle.
- Packet lock: 3-beat packet 0x11, 0x22, 0x33 (last on the third beat) with sel = 0 on beat 1 and sel = 1 on beats 2–3, out_ready = 2'b11 → all three beats appear on lane 0 in order at one per cycle; locked high after beat 1, low after beat 3; lane 1 out_valid never asserts.
- Backpressure: lane 0 slot full with out_ready[0] = 0 → in_ready = 0 for sel = 0 but in_ready = 1 for sel = 1, and a beat 0x5A reaches lane 1 while the lane 0 data stays stable.
- Out-of-range drop: N_OUT = 3, SEL_W = 2, sel = 3, 300 single-beat accepts → no lane asserts out_valid; drop_count reaches 255 and holds.
- Reset mid-packet: assert reset after beat 2 of a 4-beat packet with lane 1 full → next cycle out_valid = 0, locked = 0; the next beat routes by the current sel.
